// File: rtl/fetch_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_pkg
// Purpose  : Shared widths, instruction field positions and helper function
//            for the fetch-to-decode instruction buffer.
// Revision : 1.0  initial release
// ============================================================================
package fetch_decode_pkg;

    localparam int c_PC_WIDTH      = 16;
    localparam int c_INSTR_WIDTH   = 16;
    localparam int c_BYTE_WIDTH    = 8;
    localparam int c_OPCODE_WIDTH  = 4;
    localparam int c_REG_WIDTH     = 3;
    localparam int c_IMM_WIDTH     = 8;

    // Field LSB positions inside the 16-bit instruction word
    localparam int c_OPCODE_LSB    = 12;
    localparam int c_RD_LSB        = 9;
    localparam int c_RA_LSB        = 6;
    localparam int c_RB_LSB        = 3;
    localparam int c_IMM_LSB       = 0;

    localparam int c_DEPTH_DEFAULT = 2;

    // One buffered fetch: address plus the assembled instruction word
    typedef struct packed {
        logic [c_PC_WIDTH-1:0]    pc;
        logic [c_INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic logic [c_INSTR_WIDTH-1:0] sign_extend_imm(
        input logic [c_IMM_WIDTH-1:0] imm
    );
        return {{(c_INSTR_WIDTH-c_IMM_WIDTH){imm[c_IMM_WIDTH-1]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_field_decode.sv
`default_nettype none
// ============================================================================
// Module   : instr_field_decode
// Purpose  : Purely combinational split of a 16-bit instruction into its
//            opcode, register and sign-extended immediate fields.
// Ports    : instr  in  16  instruction word
//            opcode out  4  instr[15:12]
//            rd     out  3  instr[11:9]
//            ra     out  3  instr[8:6]
//            rb     out  3  instr[5:3]
//            imm    out 16  instr[7:0] sign-extended
// Revision : 1.0  initial release
// ============================================================================
module instr_field_decode
    import fetch_decode_pkg::*;
(
    input  logic [c_INSTR_WIDTH-1:0]  instr,
    output logic [c_OPCODE_WIDTH-1:0] opcode,
    output logic [c_REG_WIDTH-1:0]    rd,
    output logic [c_REG_WIDTH-1:0]    ra,
    output logic [c_REG_WIDTH-1:0]    rb,
    output logic [c_INSTR_WIDTH-1:0]  imm
);

    assign opcode = instr[c_OPCODE_LSB +: c_OPCODE_WIDTH];
    assign rd     = instr[c_RD_LSB     +: c_REG_WIDTH];
    assign ra     = instr[c_RA_LSB     +: c_REG_WIDTH];
    assign rb     = instr[c_RB_LSB     +: c_REG_WIDTH];
    assign imm    = sign_extend_imm(instr[c_IMM_LSB +: c_IMM_WIDTH]);

endmodule
`default_nettype wire

// File: rtl/fetch_decode_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_buffer
// Purpose  : Circular instruction buffer between fetch and decode with
//            valid/ready handshakes on both sides, flush on redirect and
//            combinational field decode of the head entry.
// Params   : DEPTH  number of entries, power of two in 2..8
// Config   : FETCH_DECODE_BUFFER_BYPASS_EN  when defined, an empty buffer
//            forwards the incoming instruction straight to decode in the
//            same cycle (not stored if decode consumes it at once).
// Ports    : clk, reset (sync, active high), flush
//            in_valid/in_ready, in_pc, instruction_code_high/low   (fetch)
//            out_valid/out_ready, out_pc, out_instr, out_opcode, out_rd,
//            out_ra, out_rb, out_imm                              (decode)
//            count  occupied entries
// Revision : 1.0  initial release
// ============================================================================
module fetch_decode_buffer
    import fetch_decode_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [c_PC_WIDTH-1:0]       in_pc,
    input  logic [c_BYTE_WIDTH-1:0]     instruction_code_high,
    input  logic [c_BYTE_WIDTH-1:0]     instruction_code_low,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [c_PC_WIDTH-1:0]       out_pc,
    output logic [c_INSTR_WIDTH-1:0]    out_instr,
    output logic [c_OPCODE_WIDTH-1:0]   out_opcode,
    output logic [c_REG_WIDTH-1:0]      out_rd,
    output logic [c_REG_WIDTH-1:0]      out_ra,
    output logic [c_REG_WIDTH-1:0]      out_rb,
    output logic [c_INSTR_WIDTH-1:0]    out_imm,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    fetch_entry_t            r_mem [DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;

    fetch_entry_t            w_in_entry;
    fetch_entry_t            w_head;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_push;
    logic                    w_pop;

    assign w_in_entry = {in_pc, instruction_code_high, instruction_code_low};
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_CNT_W'(DEPTH));

    // A retiring head frees a slot in the same cycle, so a full buffer can
    // still accept.
    assign in_ready   = !w_full || (out_valid && out_ready);

`ifdef FETCH_DECODE_BUFFER_BYPASS_EN
    logic w_bypass;

    // Flush must not leak the redirected-away instruction to decode.
    assign w_bypass  = w_empty && in_valid && !flush;
    assign w_head    = w_empty ? w_in_entry : r_mem[r_rd_ptr];
    assign out_valid = !w_empty || w_bypass;
    // A bypassed instruction consumed immediately never touches storage.
    assign w_push    = in_valid && in_ready && !flush && !(w_bypass && out_ready);
`else
    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready && !flush;
`endif

    // Only stored entries advance the read pointer.
    assign w_pop = out_valid && out_ready && !w_empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Storage is intentionally left unreset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;
    assign count     = r_count;

    instr_field_decode u_field_decode (
        .instr  (w_head.instr),
        .opcode (out_opcode),
        .rd     (out_rd),
        .ra     (out_ra),
        .rb     (out_rb),
        .imm    (out_imm)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_decode_buffer
// Purpose  : Self-checking bench for fetch_decode_buffer (DEPTH = 2) with a
//            queue of expected {pc, instr} entries in acceptance order.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_decode_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_pc;
    logic [7:0]  instr_hi;
    logic [7:0]  instr_lo;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic [3:0]  out_opcode;
    logic [2:0]  out_rd;
    logic [2:0]  out_ra;
    logic [2:0]  out_rb;
    logic [15:0] out_imm;
    logic [1:0]  count;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] q[$];
    logic [31:0] exp_e;

    fetch_decode_buffer #(.DEPTH(2)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .flush                 (flush),
        .in_valid              (in_valid),
        .in_pc                 (in_pc),
        .instruction_code_high (instr_hi),
        .instruction_code_low  (instr_lo),
        .in_ready              (in_ready),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_pc                (out_pc),
        .out_instr             (out_instr),
        .out_opcode            (out_opcode),
        .out_rd                (out_rd),
        .out_ra                (out_ra),
        .out_rb                (out_rb),
        .out_imm               (out_imm),
        .count                 (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                         input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        instr_hi  = ins[15:8];
        instr_lo  = ins[7:0];
        out_ready = rdy;
        flush     = fl;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 16'h0000, 16'hFFFF, 1'b1, 1'b1);
        step();
        step();
        reset = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        q.delete();
        tests_run++;
        if (count !== 2'd0) begin tests_failed++; $display("FAIL reset_count: got %0d required 0", count); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_basic();
        drive(1'b1, 16'h0000, 16'h1234, 1'b0, 1'b0);
        q.push_back({16'h0000, 16'h1234});
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %b required 1", out_valid); end
        tests_run++;
        if (out_instr !== 16'h1234) begin tests_failed++; $display("FAIL basic_instr: got %h required 1234", out_instr); end
        tests_run++;
        if ({out_opcode, out_rd, out_ra, out_rb} !== {4'h1, 3'd1, 3'd0, 3'd6})
            begin tests_failed++; $display("FAIL basic_fields: got op=%h rd=%0d ra=%0d rb=%0d required 1 1 0 6", out_opcode, out_rd, out_ra, out_rb); end
        tests_run++;
        if (out_imm !== 16'h0034) begin tests_failed++; $display("FAIL basic_imm: got %h required 0034", out_imm); end
        tests_run++;
        if (count !== 2'd1) begin tests_failed++; $display("FAIL basic_count: got %0d required 1", count); end
        for (int i = 0; i < 4 && q.size() != 0; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            exp_e = q.pop_front();
            tests_run++;
            if (out_valid !== 1'b1 || {out_pc, out_instr} !== exp_e)
                begin tests_failed++; $display("FAIL basic_drain: got v=%b %h required %h", out_valid, {out_pc, out_instr}, exp_e); end
            step();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tests_run++;
        if (count !== 2'd0) begin tests_failed++; $display("FAIL basic_empty: got %0d required 0", count); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 16'h0000, 16'h2000, 1'b0, 1'b0);
        q.push_back({16'h0000, 16'h2000});
        step();
        drive(1'b1, 16'h0002, 16'h2002, 1'b0, 1'b0);
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_one: got %b required 1", in_ready); end
        q.push_back({16'h0002, 16'h2002});
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'h0004, 16'h2004, 1'b0, 1'b0);
            tests_run++;
            if (in_ready !== 1'b0 || count !== 2'd2)
                begin tests_failed++; $display("FAIL bp_full: got ready=%b count=%0d required 0 2", in_ready, count); end
            tests_run++;
            if ({out_pc, out_instr} !== q[0])
                begin tests_failed++; $display("FAIL bp_head_stable: got %h required %h", {out_pc, out_instr}, q[0]); end
            step();
        end
        drive(1'b1, 16'h0004, 16'h2004, 1'b1, 1'b0);
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_on_retire: got %b required 1", in_ready); end
        exp_e = q.pop_front();
        tests_run++;
        if ({out_pc, out_instr} !== exp_e) begin tests_failed++; $display("FAIL bp_head: got %h required %h", {out_pc, out_instr}, exp_e); end
        q.push_back({16'h0004, 16'h2004});
        step();
        for (int i = 0; i < 4 && q.size() != 0; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            exp_e = q.pop_front();
            tests_run++;
            if (out_valid !== 1'b1 || {out_pc, out_instr} !== exp_e)
                begin tests_failed++; $display("FAIL bp_order: got v=%b %h required %h", out_valid, {out_pc, out_instr}, exp_e); end
            step();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tests_run++;
        if (count !== 2'd0 || out_valid !== 1'b0)
            begin tests_failed++; $display("FAIL bp_empty: got count=%0d v=%b required 0 0", count, out_valid); end
    endtask

    task automatic test_full_simul();
        drive(1'b1, 16'h0010, 16'h3010, 1'b0, 1'b0);
        q.push_back({16'h0010, 16'h3010});
        step();
        drive(1'b1, 16'h0012, 16'h3012, 1'b0, 1'b0);
        q.push_back({16'h0012, 16'h3012});
        step();
        drive(1'b1, 16'h0014, 16'h3014, 1'b1, 1'b0);
        exp_e = q.pop_front();
        tests_run++;
        if (in_ready !== 1'b1 || {out_pc, out_instr} !== exp_e)
            begin tests_failed++; $display("FAIL full_simul_head: got rdy=%b %h required 1 %h", in_ready, {out_pc, out_instr}, exp_e); end
        q.push_back({16'h0014, 16'h3014});
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tests_run++;
        if (count !== 2'd2) begin tests_failed++; $display("FAIL full_simul_count: got %0d required 2", count); end
        for (int i = 0; i < 4 && q.size() != 0; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            exp_e = q.pop_front();
            tests_run++;
            if (out_valid !== 1'b1 || {out_pc, out_instr} !== exp_e)
                begin tests_failed++; $display("FAIL full_simul_drain: got v=%b %h required %h", out_valid, {out_pc, out_instr}, exp_e); end
            step();
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 16'h0020, 16'h4020, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0022, 16'h4022, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0030, 16'h4030, 1'b0, 1'b1);
        step();
        q.delete();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tests_run++;
        if (count !== 2'd0 || out_valid !== 1'b0)
            begin tests_failed++; $display("FAIL flush_clear: got count=%0d v=%b required 0 0", count, out_valid); end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_discard_write: got v=%b required 0", out_valid); end
        drive(1'b1, 16'h0040, 16'h4040, 1'b0, 1'b0);
        q.push_back({16'h0040, 16'h4040});
        step();
        for (int i = 0; i < 4 && q.size() != 0; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            exp_e = q.pop_front();
            tests_run++;
            if (out_valid !== 1'b1 || {out_pc, out_instr} !== exp_e || count !== 2'd1)
                begin tests_failed++; $display("FAIL flush_after: got v=%b %h count=%0d required %h 1", out_valid, {out_pc, out_instr}, count, exp_e); end
            step();
        end
    endtask

    task automatic test_imm();
        drive(1'b1, 16'h0050, 16'h0080, 1'b0, 1'b0);
        q.push_back({16'h0050, 16'h0080});
        step();
        drive(1'b1, 16'h0052, 16'h007F, 1'b0, 1'b0);
        q.push_back({16'h0052, 16'h007F});
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tests_run++;
        if (out_imm !== 16'hFF80) begin tests_failed++; $display("FAIL imm_negative: got %h required FF80", out_imm); end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        exp_e = q.pop_front();
        tests_run++;
        if ({out_pc, out_instr} !== exp_e) begin tests_failed++; $display("FAIL imm_head0: got %h required %h", {out_pc, out_instr}, exp_e); end
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        tests_run++;
        if (out_imm !== 16'h007F) begin tests_failed++; $display("FAIL imm_positive: got %h required 007F", out_imm); end
        exp_e = q.pop_front();
        tests_run++;
        if ({out_pc, out_instr} !== exp_e) begin tests_failed++; $display("FAIL imm_head1: got %h required %h", {out_pc, out_instr}, exp_e); end
        step();
    endtask

`ifdef FETCH_DECODE_BUFFER_BYPASS_EN
    task automatic test_latency();
        drive(1'b1, 16'h0060, 16'hA5C3, 1'b1, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_instr !== 16'hA5C3 || out_pc !== 16'h0060)
            begin tests_failed++; $display("FAIL bypass_same_cycle: got v=%b %h %h required 1 0060 A5C3", out_valid, out_pc, out_instr); end
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tests_run++;
        if (count !== 2'd0) begin tests_failed++; $display("FAIL bypass_count: got %0d required 0", count); end
    endtask
`else
    task automatic test_latency();
        drive(1'b1, 16'h0060, 16'hA5C3, 1'b1, 1'b0);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL latency_no_bypass: got v=%b required 0", out_valid); end
        q.push_back({16'h0060, 16'hA5C3});
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        exp_e = q.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || {out_pc, out_instr} !== exp_e || count !== 2'd1)
            begin tests_failed++; $display("FAIL latency_one_cycle: got v=%b %h count=%0d required %h 1", out_valid, {out_pc, out_instr}, count, exp_e); end
        step();
    endtask
`endif

    task automatic test_reset_midstream();
        drive(1'b1, 16'h0070, 16'h7070, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0072, 16'h7072, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        drive(1'b1, 16'h0074, 16'h7074, 1'b1, 1'b0);
        step();
        reset = 1'b0;
        q.delete();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tests_run++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            begin tests_failed++; $display("FAIL reset_midstream: got count=%0d v=%b rdy=%b required 0 0 1", count, out_valid, in_ready); end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 16'h0;
        instr_hi  = 8'h0;
        instr_lo  = 8'h0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_full_simul();
        test_flush();
        test_imm();
        test_latency();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_decode_buffer.md
FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

Interface
REQ-001 Parameter DEPTH, default 2, number of instruction entries; SHALL be a power of two, 2..8.
REQ-002 Port clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port flush  in  1  discard all buffered entries (branch/jump redirect).
REQ-005 Port in_valid  in  1  fetch presents a fetched instruction this cycle.
REQ-006 Port in_pc  in  16  address of the presented instruction.
REQ-007 Port instruction_code_high  in  8  instruction bits [15:8] from instruction memory.
REQ-008 Port instruction_code_low  in  8  instruction bits [7:0] from instruction memory.
REQ-009 Port in_ready  out  1  buffer accepts input this cycle; fetch SHALL hold its PC register when low.
REQ-010 Port out_valid  out  1  head entry is valid for the decode stage.
REQ-011 Port out_ready  in  1  decode stage consumes head entry this cycle.
REQ-012 Port out_pc  out  16  PC of head entry.
REQ-013 Port out_instr  out  16  full head instruction {high, low}.
REQ-014 Port out_opcode  out  4  out_instr[15:12].
REQ-015 Port out_rd  out  3  out_instr[11:9].
REQ-016 Port out_ra  out  3  out_instr[8:6].
REQ-017 Port out_rb  out  3  out_instr[5:3].
REQ-018 Port out_imm  out  16  out_instr[7:0] sign-extended to 16 bits.
REQ-019 Port count  out  log2(DEPTH)+1  number of occupied entries.

Function
REQ-020 Input handshake: entry written when in_valid && in_ready; in_ready SHALL equal (count < DEPTH) || (out_valid && out_ready).
REQ-021 Output handshake: entry retired when out_valid && out_ready; out_valid SHALL equal (count != 0) except as REQ-033.
REQ-022 Storage: circular buffer, write and read pointers log2(DEPTH) bits, wrapping DEPTH-1 -> 0 silently.
REQ-023 Ordering: entries SHALL retire strictly in acceptance order; head outputs SHALL be stable while out_valid && !out_ready.
REQ-024 Simultaneous write and retire when full: both SHALL occur; count unchanged.
REQ-025 Simultaneous write and retire when empty (bypass disabled): write occurs, count becomes 1.
REQ-026 Write when full without retire: in_ready low; input ignored, no state change.
REQ-027 Retire when empty: impossible by REQ-021; out_ready ignored.
REQ-028 Flush: next cycle count = 0, pointers = 0, out_valid = 0; any same-cycle write SHALL be discarded.
REQ-029 Field outputs (REQ-014..018) SHALL be purely combinational from head; value when out_valid = 0 is don't-care.
REQ-030 Latency without bypass: accepted instruction SHALL appear on out_* exactly 1 cycle after acceptance.

Reset
REQ-031 reset SHALL have priority over flush and all handshakes.
REQ-032 After reset: count = 0, pointers = 0, out_valid = 0, in_ready = 1; storage contents not reset; asserting reset mid-stream SHALL drop all entries.

Configuration
REQ-033 Macro FETCH_DECODE_BUFFER_BYPASS_EN defined: when count = 0 and in_valid, out_valid = 1 and out_* driven directly from inputs (0-cycle latency); if out_ready also high, entry SHALL NOT be stored.
REQ-034 Macro undefined: no combinational path from in_* to out_*; behaviour per REQ-030.
REQ-035 flush SHALL suppress bypass in both configurations (out_valid = 0 during flush).

Structure
REQ-036 Shared package fetch_decode_pkg SHALL hold instruction field bit positions, opcode width, PC/instruction widths, DEPTH default.
REQ-037 Field extraction SHALL be sub-module instr_field_decode (combinational, 16-bit in, REQ-014..018 out).

Verification
REQ-038 Reset, then in_valid=1, pc=0x0000, high=0x12, low=0x34, out_ready=0 -> next cycle out_valid=1, out_instr=0x1234, out_opcode=0x1, out_rd=1, count=1.
REQ-039 DEPTH=2, three writes (pc 0x0,0x2,0x4) with out_ready=0 -> in_ready=0 after second; third held; retire one -> pc 0x4 accepted, order 0x0,0x2,0x4.
REQ-040 Full buffer, in_valid=1 and out_ready=1 same cycle -> count stays 2, head advances, no loss.
REQ-041 Two entries buffered, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0; subsequent write appears normally.
REQ-042 low=0x80 -> out_imm=0xFF80; low=0x7F -> out_imm=0x007F.
REQ-043 With FETCH_DECODE_BUFFER_BYPASS_EN, empty, in_valid=1, out_ready=1, instr 0xA5C3 -> same-cycle out_valid=1, out_instr=0xA5C3, count stays 0.
